// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: bit-serial add/sub/negate/pass sequencer around one shared full-adder cell
module serial_addsub_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0]       state;
    logic [WIDTH-1:0] x, y, s, s_next;
    logic [CW-1:0]    cnt;
    logic             c, sum, co;
    always_comb begin
        sum    = x[0] ^ y[0] ^ c;
        co     = (x[0] & y[0]) | (c & (x[0] ^ y[0]));
        s_next = {sum, s[WIDTH-1:1]};
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            s         <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // sub is A + ~B + 1, negate is ~A + 0 + 1; pass adds zero with no carry-in
                        x     <= op == 2'b10 ? ~a : a;
                        y     <= op == 2'b01 ? ~b : (op == 2'b00 ? b : '0);
                        c     <= op == 2'b01 || op == 2'b10;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    s   <= s_next;
                    x   <= x >> 1;
                    y   <= y >> 1;
                    c   <= co;
                    cnt <= cnt == LAST ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= s_next;
                        carry_out <= co;
                        overflow  <= c ^ co;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb_serial_addsub_seq: scoreboard bench for WIDTH=4 and WIDTH=8 instances against an arithmetic model
module tb_serial_addsub_seq;
    typedef struct {int res; int co; int ov; int t;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, start8 = 1'b0;
    logic [1:0] op = '0, op8 = '0;
    logic [3:0] a = '0, b = '0, result;
    logic [7:0] a8 = '0, b8 = '0, result8;
    logic busy, done, carry_out, overflow, busy8, done8, carry_out8, overflow8;
    int checks = 0, errors = 0, cyc = 0;
    exp_t q[$], q8[$], last;

    serial_addsub_seq #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow));
    serial_addsub_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .carry_out(carry_out8), .overflow(overflow8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // two's-complement reference from plain integer arithmetic
    function automatic exp_t model(input int w, input logic [1:0] o, input int av, input int bv);
        exp_t e;
        int m = 1 << w;
        int sa = av >= m / 2 ? av - m : av;
        int sb = bv >= m / 2 ? bv - m : bv;
        int s;
        case (o)
            2'b00: begin e.co = int'(av + bv >= m); s = sa + sb; end
            2'b01: begin e.co = int'(av >= bv); s = sa - sb; end
            2'b10: begin e.co = int'(av == 0); s = -sa; end
            default: begin e.co = 0; s = sa; end
        endcase
        e.res = s & (m - 1);
        e.ov = int'(s >= m / 2 || s < -m / 2);
        e.t = 0;
        return e;
    endfunction

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        chk("busy_done_excl", int'(busy & done), 0);
        if (done) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("result", int'(result), e.res);
                chk("carry_out", int'(carry_out), e.co);
                chk("overflow", int'(overflow), e.ov);
                chk("latency", cyc - e.t, 4);
                last = e;
            end
        end
        if (done8) begin
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                chk("result8", int'(result8), e.res);
                chk("carry_out8", int'(carry_out8), e.co);
                chk("overflow8", int'(overflow8), e.ov);
                chk("latency8", cyc - e.t, 8);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input int av, input int bv, input bit hold);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) begin chk("issue_timeout", 1, 0); return; end
        start = 1'b1; op = o; a = 4'(av); b = 4'(bv);
        e = model(4, o, av, bv);
        e.t = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        chk("busy_rise", int'(busy), 1);
        if (!hold) start = 1'b0;
        op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    endtask

    task automatic issue8(input logic [1:0] o, input int av, input int bv);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 100) begin @(negedge clk); n++; end
        if (busy8) begin chk("issue8_timeout", 1, 0); return; end
        start8 = 1'b1; op8 = o; a8 = 8'(av); b8 = 8'(bv);
        e = model(8, o, av, bv);
        e.t = cyc + 1;
        q8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
        op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0) && n < 200) begin @(negedge clk); #1; n++; end
        chk("drain", q.size() + q8.size(), 0);
    endtask

    initial begin
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({carry_out, overflow}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 4'b0101, 4'b0011, 0);
        issue(2'b00, 4'b1111, 4'b0001, 0);
        issue(2'b01, 4'b0011, 4'b0101, 0);
        issue(2'b01, 4'b1000, 4'b0001, 0);
        issue(2'b11, 4'b1010, 4'b0110, 0);
        for (int i = 0; i < 16; i++) issue(2'b10, i, 0, i < 15);
        drain();
        // start pulse mid-run with new operands must be ignored
        issue(2'b00, 4'b0110, 4'b0111, 0);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 4'b0001; b = 4'b1001;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        chk("hold_result", int'(result), last.res);
        chk("hold_carry", int'(carry_out), last.co);
        chk("hold_overflow", int'(overflow), last.ov);
        for (int i = 0; i < 40; i++)
            issue(2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), i < 39 && $urandom_range(0, 1) == 1);
        drain();
        // reset in the middle of an operation aborts it
        issue(2'b00, 4'b0011, 4'b0100, 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_flags", int'({carry_out, overflow}), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue8(2'b00, 8'h7F, 8'h01);
        issue8(2'b00, 8'hFF, 8'h01);
        issue8(2'b01, 8'h80, 8'h01);
        issue8(2'b10, 8'h80, 0);
        for (int i = 0; i < 10; i++)
            issue8(2'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_addsub_seq.md
# serial_addsub_seq

Bit-serial add/subtract/negate sequencer that drives a single shared full-adder cell over WIDTH clock cycles instead of a WIDTH-bit ripple chain. It owns the operand shift registers, the carry flop, the bit counter and the start/done handshake. It produces the same results as the ripple-carry two's-complement datapath (sum, difference, negation) at a fraction of the adder area. It sits between a host register file or test controller and the arithmetic cell.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  2  00 add A+B, 01 sub A−B, 10 negate −A, 11 pass A
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start (ignored for 10/11)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high only in DONE
- result  out  WIDTH  final sum; updated only on completion
- carry_out  out  1  unsigned carry out of MSB (for sub/negate: 1 = no borrow)
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB; forced 0 for pass

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with start=1: load X, Y and carry flop, clear bit counter, go to RUN.
  - add: X=a, Y=b, c=0
  - sub: X=a, Y=~b, c=1
  - negate: X=~a, Y=0, c=1
  - pass: X=a, Y=0, c=0
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- RUN, each cycle:
  - full adder on X[0], Y[0], c gives s, co
  - s shifts into the MSB of internal shift register S; X and Y shift right
  - c ← co; counter increments
  - when counter = WIDTH−1, the cycle also latches result ← final S, carry_out ← co and overflow ← (c_before XOR co), then goes to DONE
- start during RUN is ignored; captured operands are not disturbed by changes on a/b/op.
- result, carry_out and overflow hold their value through IDLE until the next completion. Partial sums are never visible.
- Counter width is clog2(WIDTH). No wrap beyond WIDTH−1.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, internal registers=0. An operation in flight is aborted and no done is produced.
- start accepted at edge T0:
  - busy=1 from T0 to T0+WIDTH
  - done=1 from T0+WIDTH to T0+WIDTH+1; outputs are valid from T0+WIDTH
  - latency is WIDTH cycles (4 for the default)
- Back-to-back operation: start=1 in DONE is accepted at edge T0+WIDTH+1, with busy rising the same edge. Throughput is one operation per WIDTH+1 cycles.
- done and busy are never high together.
- start held high continuously: operations repeat every WIDTH+1 cycles, with operands resampled at each acceptance.
- Reset release is safe asynchronously. The first start is sampled at the first rising edge with rst_n=1.

## Test plan
- Reset: assert rst_n=0 mid-RUN (after 2 bit cycles) → busy=0, done=0, result=0000, carry_out=0, overflow=0 immediately; no done pulse follows release.
- Add: a=0101, b=0011, op=00 → after 4 cycles done=1, result=1000, carry_out=0, overflow=1. Also a=1111, b=0001 → 0000, carry_out=1, overflow=0.
- Sub: a=0011, b=0101, op=01 → result=1110, carry_out=0, overflow=0. Also a=1000, b=0001 → 0111, carry_out=1, overflow=1.
- Negate sweep: op=10, a=0..15 back-to-back → result=(16−a) mod 16 each time. a=0000 gives carry_out=1, overflow=0; a=1000 gives 1000 with overflow=1; one done per 5 cycles.
- Handshake: pulse start mid-RUN with different a/b → ignored and the original operation completes unchanged. Change a/b during RUN → result unaffected. result holds through 10 idle cycles.
- Pass and width: op=11, a=1010 → result=1010, carry_out=0, overflow=0. Rerun the add cases with WIDTH=8 → latency 8, and 0x7F+0x01=0x80 with overflow=1.
